// File: rtl/is_weight_skew_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : is_weight_skew_feeder_pkg
//  Description : Shared definitions for the input-stationary weight skew
//                feeder: FSM state encoding and lane-slice helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package is_weight_skew_feeder_pkg;

    // Feeder FSM encoding (2 bits, fixed values)
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DONE   = 2'd3
    } fsm_state_t;

    // Each skew chain carries one valid bit alongside the lane data
    localparam int C_VLD_BITS = 1;

    // Low bit index of lane 'lane' inside a packed vector of 'width'-bit lanes
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/is_weight_skew_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module      : is_weight_skew_feeder_if
//  Description : Valid/ready input stream carrying one packed weight vector
//                (ROWS lanes of WIDTH_B bits) per beat.
//                  in_valid : producer has a vector
//                  in_ready : feeder accepts a vector
//                  in_data  : packed vector, lane r = [r*WIDTH_B +: WIDTH_B]
//  Revision    : 1.0 - initial release
// ============================================================================
interface is_weight_skew_feeder_if #(
    parameter int ROWS    = 4,
    parameter int WIDTH_B = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [ROWS*WIDTH_B-1:0] in_data;

    // Producer side
    modport master (output in_valid, output in_data, input in_ready);
    // Feeder side
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface
`default_nettype wire

// File: rtl/is_weight_skew_feeder_skew_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : skew_delay_line
//  Description : Enabled shift register of DEPTH stages, WIDTH bits each.
//                Shifts only when en=1, otherwise holds. clr zeroes every
//                stage synchronously and wins over en.
//  Ports       : clk, rst_n (async, active-low), clr, en, din, dout (tail)
//  Revision    : 1.0 - initial release
// ============================================================================
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 17
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             clr,
    input  wire logic             en,
    input  wire logic [WIDTH-1:0] din,
    output logic      [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
        end else if (en) begin
            r_pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign dout = r_pipe[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/is_weight_skew_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : is_weight_skew_feeder
//  Description : Upstream weight feeder for the input-stationary PE array.
//                Accepts num_vec packed vectors over valid/ready, skews lane r
//                by r+1 advances, flushes the chains with ROWS zero advances
//                and then pulses done for one cycle.
//  Ports       : clk, rst_n (async, active-low), reg_clear (sync clear),
//                start/num_vec (tile control, sampled in IDLE),
//                in_if (slave input stream), wei_out/wei_vld (skewed lanes),
//                pipeline_en (array advance), busy, done
//  Revision    : 1.0 - initial release
// ============================================================================
module is_weight_skew_feeder
    import is_weight_skew_feeder_pkg::*;
#(
    parameter int ROWS    = 4,
    parameter int WIDTH_B = 16,
    parameter int CNT_W   = 8
) (
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    input  wire logic                    reg_clear,
    input  wire logic                    start,
    input  wire logic [CNT_W-1:0]        num_vec,
    is_weight_skew_feeder_if.slave       in_if,
    output logic      [ROWS*WIDTH_B-1:0] wei_out,
    output logic      [ROWS-1:0]         wei_vld,
    output logic                         pipeline_en,
    output logic                         busy,
    output logic                         done
);

    localparam int                FL_W         = $clog2(ROWS + 1);
    localparam logic [FL_W-1:0]   C_FLUSH_LAST = FL_W'(ROWS - 1);
    localparam int                C_LANE_W     = WIDTH_B + C_VLD_BITS;

    fsm_state_t       r_state;
    logic [CNT_W-1:0] r_num_vec;
    logic [CNT_W-1:0] r_acc_cnt;
    logic [FL_W-1:0]  r_flush_cnt;
    logic             r_done;

    logic             w_beat;
    logic             w_adv;

    // Ready depends on state only so the producer never sees a comb loop
    assign in_if.in_ready = (r_state == ST_STREAM);
    assign w_beat         = in_if.in_valid && in_if.in_ready;

    // A bubble in STREAM freezes the chains and the array together
    assign w_adv       = w_beat || (r_state == ST_FLUSH);
    assign pipeline_en = w_adv;
    assign busy        = (r_state == ST_STREAM) || (r_state == ST_FLUSH);
    assign done        = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_num_vec   <= '0;
            r_acc_cnt   <= '0;
            r_flush_cnt <= '0;
            r_done      <= 1'b0;
        end else if (reg_clear) begin
            r_state     <= ST_IDLE;
            r_num_vec   <= '0;
            r_acc_cnt   <= '0;
            r_flush_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_acc_cnt   <= '0;
                        r_flush_cnt <= '0;
                        if (num_vec == '0) begin
                            // Empty tile: nothing to stream or flush
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_num_vec <= num_vec;
                            r_state   <= ST_STREAM;
                        end
                    end
                end
                ST_STREAM: begin
                    if (w_beat) begin
                        // Saturates at num_vec, which fits CNT_W by construction
                        r_acc_cnt <= r_acc_cnt + 1'b1;
                        if (r_acc_cnt == r_num_vec - 1'b1) begin
                            r_state     <= ST_FLUSH;
                            r_flush_cnt <= '0;
                        end
                    end
                end
                ST_FLUSH: begin
                    r_flush_cnt <= r_flush_cnt + 1'b1;
                    if (r_flush_cnt == C_FLUSH_LAST) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // One chain per lane; lane r is r+1 stages deep so vectors leave diagonally
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [C_LANE_W-1:0] w_head;
        logic [C_LANE_W-1:0] w_tail;

        // FLUSH pushes {0,0}; outside STREAM/FLUSH the chain is not enabled
        assign w_head = (r_state == ST_STREAM)
                      ? {1'b1, in_if.in_data[lane_lo(r, WIDTH_B) +: WIDTH_B]}
                      : '0;

        skew_delay_line #(
            .DEPTH (r + 1),
            .WIDTH (C_LANE_W)
        ) u_line (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (reg_clear),
            .en    (w_adv),
            .din   (w_head),
            .dout  (w_tail)
        );

        assign wei_vld[r]                                 = w_tail[WIDTH_B];
        assign wei_out[lane_lo(r, WIDTH_B) +: WIDTH_B]    = w_tail[WIDTH_B-1:0];
    end

endmodule
`default_nettype wire
